// File: rtl/uart_rx_engine.sv
// 16x-oversampled UART receiver with a first-word-fall-through receive FIFO
// and sticky frame/parity/overflow error flags.
module uart_rx_engine #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 12
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        rx_in,
  input  logic [DIV_W-1:0]            baud_div,
  input  logic                        parity_en,
  input  logic                        two_stop,
  input  logic                        rd_en,
  input  logic                        err_clr,
  output logic [7:0]                  data_out,
  output logic                        fifo_full,
  output logic                        fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        interrupt,
  output logic                        frame_error,
  output logic                        parity_error,
  output logic                        overflow
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop1, StStop2, StDone
  } state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rxs_q;
  logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d, div_last;
  logic             tick, bit_end;
  logic [3:0]       os_cnt_q, os_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             perr_q, perr_d, ferr_q, ferr_d;
  logic             push, pop;
  logic             set_ferr, set_perr, set_ovf;
  logic             frame_error_q, frame_error_d;
  logic             parity_error_q, parity_error_d;
  logic             overflow_q, overflow_d;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rxs_q     <= rx_meta_q;
    end
  end

  // Free-running oversample tick; a divisor of 0 behaves like 1.
  always_comb begin
    div_last   = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
    tick       = (tick_cnt_q >= div_last);
    tick_cnt_d = tick ? '0 : tick_cnt_q + DIV_W'(1);
  end

  assign pop = rd_en && !fifo_empty;

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    push      = 1'b0;
    set_ferr  = 1'b0;
    set_perr  = 1'b0;
    set_ovf   = 1'b0;
    bit_end   = tick && (os_cnt_q == 4'd15);

    unique case (state_q)
      StIdle: begin
        if (!rxs_q) state_d = StStart;
      end
      StStart: begin
        if (tick && (os_cnt_q == 4'd7)) begin
          if (!rxs_q) begin
            state_d   = StData;
            bit_idx_d = '0;
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d[bit_idx_q] = rxs_q;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = parity_en ? StParity : StStop1;
        end
      end
      StParity: begin
        if (bit_end) begin
          perr_d  = ^{shift_q, rxs_q};
          state_d = StStop1;
        end
      end
      StStop1: begin
        if (bit_end) begin
          ferr_d  = ferr_q | ~rxs_q;
          state_d = two_stop ? StStop2 : StDone;
        end
      end
      StStop2: begin
        if (bit_end) begin
          ferr_d  = ferr_q | ~rxs_q;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (perr_q || ferr_q) begin
          set_perr = perr_q;
          set_ferr = ferr_q;
        end else if (fifo_full && !pop) begin
          set_ovf = 1'b1;
        end else begin
          push = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    os_cnt_d = (state_d != state_q) ? 4'd0 : (tick ? os_cnt_q + 4'd1 : os_cnt_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      os_cnt_q   <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      os_cnt_q   <= os_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  // Sticky flags: a new error in the same cycle as err_clr wins.
  always_comb begin
    frame_error_d  = (err_clr ? 1'b0 : frame_error_q)  | set_ferr;
    parity_error_d = (err_clr ? 1'b0 : parity_error_q) | set_perr;
    overflow_d     = (err_clr ? 1'b0 : overflow_q)     | set_ovf;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_error_q  <= 1'b0;
      parity_error_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      frame_error_q  <= frame_error_d;
      parity_error_q <= parity_error_d;
      overflow_q     <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (pop && !push) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_count   = count_q;
  assign data_out     = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign interrupt    = !fifo_empty;
  assign frame_error  = frame_error_q;
  assign parity_error = parity_error_q;
  assign overflow     = overflow_q;

endmodule
